cpu_io_bridge: RTL and testbench

//  Host-side counterpart of the CPU data path: feeds operands into the CPU `entrada` port and collects results from `saida`.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/io_fifo.sv | 70 +++++++
 rtl/cpu_io_bridge.sv | 121 ++++++++++++
 tb/tb_cpu_io_bridge.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU data path: word widths, register control codes
// and the state encoding of the result-capture FSM.
package cpu_pkg;

    localparam int DATA_W = 5;
    localparam int CTRL_W = 5;

    localparam logic [CTRL_W-1:0] REG_HOLD  = 5'd0;
    localparam logic [CTRL_W-1:0] REG_LOAD  = 5'd1;
    localparam logic [CTRL_W-1:0] REG_CLEAR = 5'd2;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cap_state_e;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with a combinational head word. A push into a full
// FIFO is accepted when a pop frees the slot on the same edge.
module io_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// Host-side bridge for the CPU data path: feeds operands to Rx via entrada and
// collects Rz results from saida by snooping the tx/tz control codes.
module cpu_io_bridge #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int CTRL_W = cpu_pkg::CTRL_W,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic [CTRL_W-1:0] tx,
    input  logic [CTRL_W-1:0] tz,
    input  logic [DATA_W-1:0] saida,
    output logic [DATA_W-1:0] entrada,
    output logic              underflow,
    output logic              overflow,
    input  logic              clr_flags
);

    import cpu_pkg::*;

    localparam logic [CTRL_W-1:0] LOAD_C = CTRL_W'(REG_LOAD);

    logic              tx_load, tz_load;
    logic              in_push, in_full, in_empty;
    logic [DATA_W-1:0] in_head;
    logic              out_push, out_pop, out_full, out_empty;
    logic [DATA_W-1:0] out_head;
    cap_state_e        state_q, state_d;
    logic              underflow_q, underflow_d;
    logic              overflow_q, overflow_d;

    assign tx_load = (tx == LOAD_C);
    assign tz_load = (tz == LOAD_C);

    assign in_push  = in_valid && in_ready;
    assign in_ready = !in_full;
    assign entrada  = in_empty ? '0 : in_head;

    io_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_operand_fifo (
        .clk     (clock),
        .srst    (reset),
        .push_i  (in_push),
        .pop_i   (tx_load),
        .data_i  (in_data),
        .head_o  (in_head),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    assign out_pop   = out_valid && out_ready;
    assign out_valid = !out_empty;
    assign out_data  = out_head;

    io_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_result_fifo (
        .clk     (clock),
        .srst    (reset),
        .push_i  (out_push),
        .pop_i   (out_pop),
        .data_i  (saida),
        .head_o  (out_head),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

    // Rz only shows the new value one cycle after the load edge, hence PEND.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = tz_load ? PEND : IDLE;
            PEND:    state_d = tz_load ? PEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_push = 1'b0;
        if (state_q == PEND) begin
            out_push = 1'b1;
        end
    end

    // Setting a flag overrides a simultaneous clear.
    always_comb begin
        underflow_d = clr_flags ? 1'b0 : underflow_q;
        overflow_d  = clr_flags ? 1'b0 : overflow_q;
        if (tx_load && in_empty) begin
            underflow_d = 1'b1;
        end
        if (out_push && out_full && !out_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge: operand feed, underflow, result capture
// latency, overflow/drop, full-FIFO pass-through and mid-operation reset.
module tb_cpu_io_bridge;

    localparam logic [4:0] HOLD  = 5'd0;
    localparam logic [4:0] LOAD  = 5'd1;
    localparam logic [4:0] CLEAR = 5'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_ready = 1'b0;
    logic [4:0] tx = HOLD;
    logic [4:0] tz = HOLD;
    logic [4:0] saida = '0;
    logic [4:0] entrada;
    logic       underflow;
    logic       overflow;
    logic       clr_flags = 1'b0;

    int errors = 0;
    int checks = 0;

    cpu_io_bridge #(.DATA_W(5), .CTRL_W(5), .DEPTH(4)) dut (
        .clock     (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .tx        (tx),
        .tz        (tz),
        .saida     (saida),
        .entrada   (entrada),
        .underflow (underflow),
        .overflow  (overflow),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs depend only on state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_entrada", entrada, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_overflow", overflow, 0);

        // Operand feed: push 3,7,9 then load Rx three times.
        in_valid = 1'b1; in_data = 5'd3; tick();
        in_data = 5'd7; tick();
        in_data = 5'd9; tick();
        in_valid = 1'b0;
        chk("feed_head0", entrada, 3);
        tx = LOAD; tick();
        chk("feed_head1", entrada, 7);
        chk("feed_ready", in_ready, 1);
        tick();
        chk("feed_head2", entrada, 9);
        tick();
        tx = HOLD;
        chk("feed_empty", entrada, 0);
        chk("feed_no_underflow", underflow, 0);

        // Underflow on empty load, clear, and set-wins-over-clear.
        tx = LOAD; tick(); tx = HOLD;
        chk("uf_set", underflow, 1);
        chk("uf_entrada", entrada, 0);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("uf_clear", underflow, 0);
        tx = LOAD; clr_flags = 1'b1; tick(); tx = HOLD; clr_flags = 1'b0;
        chk("uf_set_wins", underflow, 1);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("uf_clear2", underflow, 0);

        // Capture latency: tz LOAD at edge N, result visible after N+1.
        tz = LOAD; tick(); tz = HOLD; saida = 5'd12;
        chk("lat_not_yet", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 12);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("lat_drained", out_valid, 0);

        // Five back-to-back loads into a 4-deep FIFO: fifth result dropped.
        tz = LOAD; tick();
        saida = 5'd1; tick();
        saida = 5'd2; tick();
        saida = 5'd3; tick();
        saida = 5'd4; tick();
        tz = HOLD;
        chk("ovf_not_yet", overflow, 0);
        chk("ovf_head_pre", out_data, 1);
        saida = 5'd5; tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), out_data, i);
            tick();
        end
        out_ready = 1'b0;
        chk("ovf_empty", out_valid, 0);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Full result FIFO with a pop on the capture edge: no drop.
        tz = LOAD; tick();
        saida = 5'd10; tick();
        saida = 5'd11; tick();
        saida = 5'd12; tick();
        tz = HOLD; saida = 5'd13; tick();
        chk("pass_head", out_data, 10);
        tz = LOAD; tick();
        tz = HOLD; saida = 5'd14; out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pass_no_ovf", overflow, 0);
        out_ready = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            chk($sformatf("pass_order%0d", i), out_data, i);
            tick();
        end
        out_ready = 1'b0;
        chk("pass_empty", out_valid, 0);

        // CLEAR on Rz is not a result.
        tz = CLEAR; saida = 5'd21; tick(); tz = HOLD; tick();
        chk("clear_no_capture", out_valid, 0);

        // Mid-operation reset: full operand FIFO, sticky flag, pending capture.
        tx = LOAD; tick(); tx = HOLD;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 5'(i + 20);
            tick();
        end
        chk("pre_rst_full", in_ready, 0);
        in_valid = 1'b0;
        tz = LOAD; tick(); tz = HOLD; saida = 5'd17;
        chk("pre_rst_underflow", underflow, 1);
        reset = 1'b1; in_valid = 1'b1; tx = LOAD; out_ready = 1'b1; tick();
        reset = 1'b0; in_valid = 1'b0; tx = HOLD; out_ready = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_entrada", entrada, 0);
        chk("mid_rst_underflow", underflow, 0);
        chk("mid_rst_overflow", overflow, 0);
        tick();
        chk("mid_rst_no_capture", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
